// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;
  typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_e;
  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; the owner keeps the last-grant history.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic  elig_i_i,
  input  logic  elig_d_i,
  input  port_e last_gnt_i,
  output logic  gnt_valid_o,
  output port_e gnt_id_o
);
  always_comb begin
    gnt_valid_o = elig_i_i | elig_d_i;
    gnt_id_o    = PORT_I;
    if (elig_i_i && elig_d_i)
      gnt_id_o = (last_gnt_i == PORT_I) ? PORT_D : PORT_I;
    else if (elig_d_i)
      gnt_id_o = PORT_D;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data requesters, one transaction
// in flight, round-robin on ties, error completion after TIMEOUT idle-ack cycles.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  output logic              i_err,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_rd_wr,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_err,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);
  localparam int CNT_W = $clog2(TIMEOUT);

  state_e            state_q, state_d;
  port_e             last_q, last_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              en_q, en_d, rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic              i_done_q, i_done_d, d_done_q, d_done_d;
  logic              i_err_q, i_err_d, d_err_q, d_err_d;
  logic              gnt_valid;
  port_e             gnt_id;

  // A port whose done is still high is ignored so a lingering req is not re-issued.
  rr_arb2 u_rr (
    .elig_i_i   (state_q == IDLE && i_req && !i_done_q),
    .elig_d_i   (state_q == IDLE && d_req && !d_done_q),
    .last_gnt_i (last_q),
    .gnt_valid_o(gnt_valid),
    .gnt_id_o   (gnt_id)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= PORT_D;
      wait_q    <= '0;
      en_q      <= 1'b0;
      rw_q      <= MEM_READ;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      i_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      wait_q    <= wait_d;
      en_q      <= en_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      i_err_q   <= i_err_d;
      d_err_q   <= d_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    wait_d    = wait_q;
    en_d      = en_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    i_err_d   = 1'b0;
    d_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          en_d   = 1'b1;
          wait_d = '0;
          last_d = gnt_id;
          if (gnt_id == PORT_I) begin
            state_d = BUSY_I;
            addr_d  = i_addr;
            rw_d    = MEM_READ;
          end else begin
            state_d = BUSY_D;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            rw_d    = d_rd_wr;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack) begin
          en_d    = 1'b0;
          state_d = IDLE;
          if (state_q == BUSY_I) begin
            i_done_d  = 1'b1;
            i_rdata_d = mem_rdata;
          end else begin
            d_done_d = 1'b1;
            if (rw_q == MEM_READ) d_rdata_d = mem_rdata;
          end
        end else if (wait_q == CNT_W'(TIMEOUT - 1)) begin
          en_d    = 1'b0;
          state_d = IDLE;
          if (state_q == BUSY_I) begin
            i_done_d = 1'b1;
            i_err_d  = 1'b1;
          end else begin
            d_done_d = 1'b1;
            d_err_d  = 1'b1;
          end
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_en    = en_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_rd_wr = rw_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign i_err     = i_err_q;
  assign d_err     = d_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a one-cycle-ack memory model.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_rd_wr = 1'b1;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_done, i_err, d_done, d_err, mem_en, mem_rd_wr, mem_ack;
  logic [31:0] mem_rdata = '0;
  logic        ack_auto = 1'b0, spur_ack = 1'b0, auto_en = 1'b0;
  logic [31:0] mem_q [0:255];
  logic [255:0] mem_vld = '0;
  int          errors = 0, checks = 0;
  int          i_done_cnt = 0, d_done_cnt = 0;
  logic [31:0] gnt_log[$];
  logic        en_prev = 1'b0;

  assign mem_ack = ack_auto | spur_ack;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_err(i_err),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_rd_wr(d_rd_wr),
    .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd_wr(mem_rd_wr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return (a == 32'h8002_0000) ? 32'h27BD_FFE8 : (a ^ 32'h5A5A_5A5A);
  endfunction

  // Memory answers one cycle after it first sees mem_en.
  always @(negedge clk) begin
    if (auto_en && mem_en && !ack_auto) begin
      ack_auto <= 1'b1;
      if (!mem_rd_wr) begin
        mem_q[mem_addr[9:2]]   <= mem_wdata;
        mem_vld[mem_addr[9:2]] <= 1'b1;
      end
      mem_rdata <= mem_vld[mem_addr[9:2]] ? mem_q[mem_addr[9:2]] : mem_init(mem_addr);
    end else begin
      ack_auto <= 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (i_done) i_done_cnt++;
    if (d_done) d_done_cnt++;
    if (mem_en && !en_prev) gnt_log.push_back(mem_addr);
    en_prev = mem_en;
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_en, mem_rd_wr, i_done, d_done, i_err, d_err} !== 6'b010000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 010000", {mem_en, mem_rd_wr, i_done, d_done, i_err, d_err});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      errors++; $display("FAIL reset_mem_bus: got %h want 0", {mem_addr, mem_wdata});
    end
    checks++;
    if ({i_rdata, d_rdata} !== 64'h0) begin
      errors++; $display("FAIL reset_rdata: got %h want 0", {i_rdata, d_rdata});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_fetch();
    int n0 = i_done_cnt;
    int g0 = gnt_log.size();
    auto_en = 1'b1;
    i_req = 1'b1; i_addr = 32'h8002_0000;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_rd_wr, mem_addr} !== {2'b11, 32'h8002_0000}) begin
      errors++; $display("FAIL fetch_issue: got %b%b %h want 11 80020000", mem_en, mem_rd_wr, mem_addr);
    end
    @(negedge clk);
    checks++;
    if ({i_done, i_err, i_rdata} !== {2'b10, 32'h27BD_FFE8}) begin
      errors++; $display("FAIL fetch_done: got %b%b %h want 10 27bdffe8", i_done, i_err, i_rdata);
    end
    @(negedge clk);
    checks++;
    if ({i_done, mem_en} !== 2'b00) begin
      errors++; $display("FAIL fetch_no_reissue: got done/en %b want 00", {i_done, mem_en});
    end
    i_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ((i_done_cnt - n0) != 1 || (gnt_log.size() - g0) != 1) begin
      errors++; $display("FAIL fetch_count: got dones=%0d grants=%0d want 1 1", i_done_cnt - n0, gnt_log.size() - g0);
    end
  endtask

  task automatic test_store_load();
    d_req = 1'b1; d_rd_wr = 1'b0; d_addr = 32'h8011_FFF0; d_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_rd_wr, mem_wdata} !== {2'b10, 32'hCAFE_F00D}) begin
      errors++; $display("FAIL store_issue: got %b%b %h want 10 cafef00d", mem_en, mem_rd_wr, mem_wdata);
    end
    @(negedge clk);
    checks++;
    if ({d_done, d_err, d_rdata} !== {2'b10, 32'h0}) begin
      errors++; $display("FAIL store_done: got %b%b %h want 10 00000000", d_done, d_err, d_rdata);
    end
    d_req = 1'b0;
    @(negedge clk);
    d_req = 1'b1; d_rd_wr = 1'b1; d_wdata = 32'h0;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_rd_wr, mem_addr} !== {2'b11, 32'h8011_FFF0}) begin
      errors++; $display("FAIL load_issue: got %b%b %h want 11 8011fff0", mem_en, mem_rd_wr, mem_addr);
    end
    @(negedge clk);
    checks++;
    if ({d_done, d_rdata} !== {1'b1, 32'hCAFE_F00D}) begin
      errors++; $display("FAIL load_done: got %b %h want 1 cafef00d", d_done, d_rdata);
    end
    d_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tie();
    int g0 = gnt_log.size();
    int cyc = 0;
    logic [31:0] exp_order [4] = '{32'h1000, 32'h2000, 32'h1000, 32'h2000};
    i_addr = 32'h1000; d_addr = 32'h2000; d_rd_wr = 1'b1;
    i_req = 1'b1; d_req = 1'b1;
    while (gnt_log.size() - g0 < 4 && cyc < 40) begin
      @(negedge clk); cyc++;
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (gnt_log.size() - g0 != 4) begin
      errors++; $display("FAIL tie_grants: got %0d want 4", gnt_log.size() - g0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (gnt_log[g0 + k] !== exp_order[k]) begin
          errors++; $display("FAIL tie_order[%0d]: got %h want %h", k, gnt_log[g0 + k], exp_order[k]);
        end
      end
    end
    checks++;
    if ({i_rdata, d_rdata} !== {32'h1000 ^ 32'h5A5A_5A5A, 32'h2000 ^ 32'h5A5A_5A5A}) begin
      errors++; $display("FAIL tie_rdata: got %h %h want %h %h", i_rdata, d_rdata,
                         32'h1000 ^ 32'h5A5A_5A5A, 32'h2000 ^ 32'h5A5A_5A5A);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] prev = d_rdata;
    int early = 0;
    auto_en = 1'b0;
    d_req = 1'b1; d_rd_wr = 1'b1; d_addr = 32'h3000;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b1) begin
      errors++; $display("FAIL timeout_grant: got mem_en=%b want 1", mem_en);
    end
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      if (n < 64 && (d_done || !mem_en)) early++;
    end
    checks++;
    if (early != 0) begin
      errors++; $display("FAIL timeout_early: got %0d bad cycles want 0", early);
    end
    checks++;
    if ({d_done, d_err, d_rdata} !== {2'b11, prev}) begin
      errors++; $display("FAIL timeout_done: got %b%b %h want 11 %h", d_done, d_err, d_rdata, prev);
    end
    d_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_en, d_done, d_err} !== 3'b000) begin
      errors++; $display("FAIL timeout_after: got %b want 000", {mem_en, d_done, d_err});
    end
  endtask

  task automatic test_reset_mid_busy();
    int n0;
    auto_en = 1'b0;
    i_req = 1'b1; i_addr = 32'h4000;
    repeat (3) @(negedge clk);
    n0 = i_done_cnt;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_en, i_done} !== 2'b00) begin
      errors++; $display("FAIL midreset_abort: got en/done %b want 00", {mem_en, i_done});
    end
    reset = 1'b0; i_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (i_done_cnt != n0) begin
      errors++; $display("FAIL midreset_nodone: got %0d dones want 0", i_done_cnt - n0);
    end
    auto_en = 1'b1;
    i_addr = 32'h5000; d_addr = 32'h6000; d_rd_wr = 1'b1;
    i_req = 1'b1; d_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_addr} !== {1'b1, 32'h5000}) begin
      errors++; $display("FAIL midreset_tie: got %b %h want 1 00005000", mem_en, mem_addr);
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_spurious_ack();
    int n0 = i_done_cnt + d_done_cnt;
    int g0 = gnt_log.size();
    auto_en = 1'b0;
    spur_ack = 1'b1;
    @(negedge clk);
    spur_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ((i_done_cnt + d_done_cnt) != n0 || mem_en !== 1'b0 || gnt_log.size() != g0) begin
      errors++; $display("FAIL spurious_ack: got dones=%0d en=%b want 0 0", i_done_cnt + d_done_cnt - n0, mem_en);
    end
    auto_en = 1'b1;
    i_req = 1'b1; i_addr = 32'h8002_0000;
    repeat (2) @(negedge clk);
    checks++;
    if ({i_done, i_err, i_rdata} !== {2'b10, 32'h27BD_FFE8}) begin
      errors++; $display("FAIL spurious_followup: got %b%b %h want 10 27bdffe8", i_done, i_err, i_rdata);
    end
    i_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store_load();
    test_tie();
    test_timeout();
    test_reset_mid_busy();
    test_spurious_ack();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
